// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that funnels NREQ write requesters into one register-file write port.
// Optional macro REG31_DISCARD_EN: grants targeting address 31 are consumed without writing.
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [5*NREQ-1:0]       req_addr,
  input  logic [DW*NREQ-1:0]      req_data,
  input  logic                    stall,
  output logic [NREQ-1:0]         gnt,
  output logic                    wr_en,
  output logic [4:0]              wr_addr,
  output logic [DW-1:0]           wr_data,
  output logic [$clog2(NREQ)-1:0] wr_src
);

  localparam int SW = $clog2(NREQ);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [SW-1:0] wr_src_q;

  logic          found;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] cand;
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    gnt      = '0;
    sel_addr = '0;
    sel_data = '0;
    wr_en_d  = 1'b0;
    ptr_d    = ptr_q;

    // NREQ is a power of two, so the SW-bit add wraps the search modulo NREQ.
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr_q + SW'(k);
      if (!reset && !stall && !found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end

    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end

    for (int unsigned i = 0; i < NREQ; i++) begin
      if (SW'(i) == gnt_idx) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[DW*i +: DW];
      end
    end

    wr_en_d = found;
`ifdef REG31_DISCARD_EN
    if (sel_addr == 5'd31) begin
      wr_en_d = 1'b0;
    end
`endif

    if (found) begin
      ptr_d = gnt_idx + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_src_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      if (wr_en_d) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        wr_src_q  <= gnt_idx;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a round-robin reference model.
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
`ifdef REG31_DISCARD_EN
  localparam bit DISC = 1'b1;
`else
  localparam bit DISC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [5*N-1:0]  req_addr;
  logic [DW*N-1:0] req_data;
  logic            stall;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      wr_src;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  regfile_write_arbiter #(.NREQ(N), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_addr(req_addr),
    .req_data(req_data),
    .stall   (stall),
    .gnt     (gnt),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_src  (wr_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Reference model: pointer as an integer, registered write as plain variables.
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [63:0] m_wdata;
  int          m_wsrc;
  int          wait_cnt [N];

  initial begin
    int gi;
    int idx;
    logic [N-1:0] eg;
    logic [4:0] a;
    m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_wsrc = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(posedge clk);
    while (!done) begin
      @(negedge clk);
      eg = '0;
      gi = -1;
      if (!reset && !stall) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (gi < 0 && req[idx]) gi = idx;
        end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      chk("gnt", gnt, eg);
      chk("wr_en", wr_en, m_wen);
      chk("wr_addr", wr_addr, m_waddr);
      chk("wr_data", wr_data, m_wdata);
      chk("wr_src", wr_src, m_wsrc);

      for (int i = 0; i < N; i++) begin
        if (reset || !req[i]) wait_cnt[i] = 0;
        else if (!stall) begin
          if (gnt[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            chk("starve", wait_cnt[i] < N, 1);
          end
        end
      end

      if (reset) begin
        m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_wsrc = 0;
      end else if (gi >= 0) begin
        a = req_addr[5*gi +: 5];
        m_wen = !(DISC && a == 5'd31);
        if (m_wen) begin
          m_waddr = a;
          m_wdata = req_data[DW*gi +: DW];
          m_wsrc  = gi;
        end
        m_ptr = (gi + 1) % N;
      end else begin
        m_wen = 0;
      end
    end
  end

  initial begin
    logic [N-1:0] g;
    reset = 1'b1; stall = 1'b0; req = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    smp();
    chk("rst_gnt", gnt, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);

    tick();
    reset = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_addr[5*i +: 5]   = 5'(i + 1);
      req_data[DW*i +: DW] = 64'h100 + 64'(i);
    end
    smp(); chk("first_gnt", gnt, 4'b0001);
    tick(); smp();
    chk("first_wr_en", wr_en, 1); chk("first_wr_src", wr_src, 0);
    chk("rr_addr0", wr_addr, 1); chk("rr_gnt1", gnt, 4'b0010);
    tick(); smp(); chk("rr_addr1", wr_addr, 2); chk("rr_gnt2", gnt, 4'b0100);
    tick(); smp(); chk("rr_addr2", wr_addr, 3); chk("rr_gnt3", gnt, 4'b1000);
    tick(); smp(); chk("rr_addr3", wr_addr, 4); chk("rr_gnt4", gnt, 4'b0001);
    tick(); smp(); chk("rr_addr4", wr_addr, 1); chk("rr_gnt5", gnt, 4'b0010);

    tick(); req = 4'b0011;
    smp(); chk("wrap_gnt", gnt, 4'b0001); chk("wrap_wr_src", wr_src, 1);
    tick(); req = 4'b0010;
    smp(); chk("ptr1_gnt", gnt, 4'b0010);

    tick(); req = 4'b1111; stall = 1'b1;
    smp(); chk("stall1_gnt", gnt, 0); chk("stall1_wr_en", wr_en, 1); chk("stall1_src", wr_src, 1);
    tick(); smp(); chk("stall2_gnt", gnt, 0); chk("stall2_wr_en", wr_en, 0);
    tick(); smp(); chk("stall3_gnt", gnt, 0); chk("stall3_wr_en", wr_en, 0); chk("stall3_hold", wr_addr, 2);
    tick(); stall = 1'b0;
    smp(); chk("unstall_gnt", gnt, 4'b0100);

    tick(); req = 4'b0001; req_addr[4:0] = 5'd31; req_data[DW-1:0] = 64'hDEAD;
    smp(); chk("r31_gnt", gnt, 4'b0001);
    tick(); req = 4'b0010;
    smp();
    if (DISC) begin
      chk("r31_wr_en", wr_en, 0); chk("r31_hold_addr", wr_addr, 3); chk("r31_hold_src", wr_src, 2);
    end else begin
      chk("r31_wr_en", wr_en, 1); chk("r31_wr_addr", wr_addr, 31); chk("r31_wr_data", wr_data, 64'hDEAD);
    end
    chk("pre_rst_gnt", gnt, 4'b0010);

    tick(); reset = 1'b1; req = 4'b1111;
    smp(); chk("rstcyc_wr_en", wr_en, 1); chk("rstcyc_wr_addr", wr_addr, 2); chk("rstcyc_gnt", gnt, 0);
    tick(); reset = 1'b0; req = 4'b0100;
    smp(); chk("postrst_wr_en", wr_en, 0); chk("postrst_wr_addr", wr_addr, 0); chk("postrst_gnt", gnt, 4'b0100);
    tick(); req = '0;

    for (int c = 0; c < 3000; c++) begin
      smp();
      g = gnt;
      tick();
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req[i] || g[i]) begin
          req[i]               = ($urandom_range(0, 2) != 0);
          req_addr[5*i +: 5]   = 5'($urandom);
          req_data[DW*i +: DW] = {$urandom, $urandom};
        end
      end
    end

    done = 1'b1;
    smp(); smp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NREQ SHALL have default 4 and set the number of requesters, a power of two from 2 to 8.
REQ-002 Parameter DW SHALL have default 64 and set the write data width.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be input, 1 bit: reset is synchronous and active-high.
REQ-005 Port req SHALL be input, NREQ bits: per-requester write request.
REQ-006 Port req_addr SHALL be input, 5*NREQ bits: requester i's register address in bits [5i+4:5i].
REQ-007 Port req_data SHALL be input, DW*NREQ bits: requester i's write data in bits [DW*i+DW-1:DW*i].
REQ-008 Port stall SHALL be input, 1 bit: blocks new grants while high.
REQ-009 Port gnt SHALL be output, NREQ bits: one-hot grant, or zero.
REQ-010 Port wr_en SHALL be output, 1 bit: enable driven into the 5:32 write-address decoder.
REQ-011 Port wr_addr SHALL be output, 5 bits: register write address.
REQ-012 Port wr_data SHALL be output, DW bits: register write data.
REQ-013 Port wr_src SHALL be output, log2(NREQ) bits: index of the requester owning the current write.

Function
REQ-014 gnt SHALL be combinational from req, stall, reset and the round-robin pointer ptr, with at most one bit set.
REQ-015 gnt SHALL be all-zero when stall=1, reset=1 or req=0.
REQ-016 Arbitration SHALL pick the first set req bit searching upward from ptr, modulo NREQ; the search wraps from NREQ-1 to 0.
REQ-017 On a grant to i, ptr SHALL become (i+1) mod NREQ at the next edge; with no grant, ptr SHALL hold.
REQ-018 A requester SHALL hold req, req_addr and req_data stable until it sees gnt; sampling occurs only in the grant cycle.
REQ-019 The edge after a grant to i SHALL register wr_en=1, wr_addr=req_addr[i], wr_data=req_data[i] and wr_src=i.
REQ-020 Latency from grant cycle to wr_en=1 SHALL be exactly one cycle, with throughput of one write per cycle.
REQ-021 In any cycle not preceded by a grant, wr_en SHALL be 0, and wr_addr, wr_data and wr_src SHALL hold their last values.
REQ-022 Raising stall SHALL NOT cancel a write already registered, so wr_en=1 still appears in the cycle after the last grant.
REQ-023 A continuously asserted req SHALL be granted within NREQ non-stalled cycles.
REQ-024 Several requesters targeting the same address SHALL be serialized in grant order, with no merging.

Reset
REQ-025 With reset=1 at an edge, ptr SHALL become 0, wr_en 0, wr_addr 0, wr_data 0 and wr_src 0.
REQ-026 A write visible on outputs in the reset cycle SHALL remain visible for that cycle and be cleared at the following edge.
REQ-027 No grant SHALL issue in a reset cycle, so no write is lost silently.

Configuration
REQ-028 With macro REG31_DISCARD_EN defined, a grant to address 31 (zero register) SHALL still assert gnt and advance ptr, but the following cycle SHALL keep wr_en=0 and hold wr_addr, wr_data and wr_src.
REQ-029 Without REG31_DISCARD_EN, address 31 SHALL be written like any other address.

Verification
REQ-030 Reset, then req=4'b1111 -> gnt=4'b0001; next cycle wr_en=1, wr_src=0, wr_addr=req_addr[0].
REQ-031 req=4'b1111 held with distinct addresses 1,2,3,4 -> gnt sequence 0001, 0010, 0100, 1000, 0001; wr_addr sequence 1,2,3,4,1, one cycle delayed.
REQ-032 ptr=2 (after a grant to 1), req=4'b0011 -> gnt=4'b0001 (wrap); ptr becomes 1.
REQ-033 stall=1 for 3 cycles with req=4'b1111 -> gnt=0 in those cycles, wr_en=0 from the second stalled cycle, and ptr unchanged after stall drops.
REQ-034 req0 alone with addr=31 and data=0xDEAD -> with REG31_DISCARD_EN, wr_en=0 the next cycle; without it, wr_en=1, wr_addr=31, wr_data=0xDEAD.
REQ-035 reset asserted in a cycle with wr_en=1 -> wr_en=0 and ptr=0 next cycle; req=4'b0100 afterwards -> gnt=4'b0100.
